// File: rtl/sum_scale_pipe_pkg.sv
// Shared width helper and the doubling/saturation rule for the sum-and-scale pipeline.
package sum_scale_pipe_pkg;

    // Widest result the doubling function handles; narrower data is zero-extended into it.
    localparam int DW_MAX = 64;

    function automatic int out_w_default(input int in_w, input int stages);
        return in_w + 2 + stages;
    endfunction

    // Returns {doubled value, overflow event}. Only the low w bits of data are meaningful.
    function automatic logic [DW_MAX:0] dbl_sat(input logic [DW_MAX-1:0] data,
                                                input logic             sat,
                                                input int               w);
        logic [DW_MAX-1:0] mask;
        logic [DW_MAX-1:0] top;
        logic [DW_MAX-1:0] res;
        logic              ev;
        mask = {DW_MAX{1'b1}} >> (DW_MAX - w);
        top  = mask & ~(mask >> 1);
        res  = (data << 1) & mask;
        ev   = 1'b0;
        if ((data & top) != '0) begin
            if (sat) begin
                // An already-clamped value passes through without counting as a new overflow
                res = mask;
                ev  = ((data & mask) != mask);
            end else begin
                ev  = 1'b1;
            end
        end
        return {res, ev};
    endfunction

endpackage

// File: rtl/sum_scale_pipe_stage.sv
// One elastic register slice: accepts a beat from the previous stage and stores it doubled.
module scale_pipe_stage
    import sum_scale_pipe_pkg::*;
#(
    parameter int OUT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [OUT_W-1:0] up_data,
    input  logic             up_sat,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [OUT_W-1:0] dn_data,
    output logic             dn_sat,
    output logic             ovf_evt
);

    logic [DW_MAX:0] dbl;
    logic            load;

    assign dbl      = dbl_sat(DW_MAX'(up_data), up_sat, OUT_W);
    assign up_ready = !dn_valid | dn_ready;
    assign load     = up_valid & up_ready & !flush;
    assign ovf_evt  = load & dbl[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_sat   <= 1'b0;
        end else begin
            if (flush) begin
                dn_valid <= 1'b0;
            end else if (up_ready) begin
                dn_valid <= up_valid;
            end
            if (load) begin
                dn_data <= dbl[OUT_W:1];
                dn_sat  <= up_sat;
            end
        end
    end

endmodule

// File: rtl/sum_scale_pipe.sv
// Elastic pipeline computing (a+b+c)*2^STAGES with per-beat wrap/saturate, flush,
// occupancy tracking and a sticky overflow flag.
module sum_scale_pipe
    import sum_scale_pipe_pkg::*;
#(
    parameter int IN_W   = 5,
    parameter int STAGES = 4,
    parameter int OUT_W  = out_w_default(IN_W, STAGES),
    parameter int OCC_W  = $clog2(STAGES + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [IN_W-1:0]  c,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] sum,
    output logic [OCC_W-1:0] occupancy,
    output logic             ovf
);

    logic             vld   [0:STAGES];
    logic             sat_q [0:STAGES];
    logic [OUT_W-1:0] data  [0:STAGES];
    logic             rdy   [0:STAGES+1];
    logic             evt   [1:STAGES];
    logic             evt_any;
    logic [IN_W+1:0]  sum3;
    logic [OUT_W-1:0] d0_next;
    logic             in_xfer;
    logic             out_xfer;

    assign sum3 = {2'b00, a} + {2'b00, b} + {2'b00, c};

    always_comb begin
        d0_next            = '0;
        d0_next[IN_W+1:0]  = sum3;
    end

    assign rdy[STAGES+1] = out_ready;
    assign rdy[0]        = !vld[0] | rdy[1];
    assign in_ready      = rdy[0] & !flush;
    assign in_xfer       = in_valid & in_ready;
    assign out_xfer      = vld[STAGES] & out_ready;

    // stage 0: exact three-operand sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld[0]   <= 1'b0;
            data[0]  <= '0;
            sat_q[0] <= 1'b0;
        end else begin
            if (flush) begin
                vld[0] <= 1'b0;
            end else if (rdy[0]) begin
                vld[0] <= in_valid;
            end
            if (in_xfer) begin
                data[0]  <= d0_next;
                sat_q[0] <= sat_en;
            end
        end
    end

    // stages 1..STAGES: one doubling each
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        scale_pipe_stage #(.OUT_W(OUT_W)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (vld[k-1]),
            .up_ready (rdy[k]),
            .up_data  (data[k-1]),
            .up_sat   (sat_q[k-1]),
            .dn_valid (vld[k]),
            .dn_ready (rdy[k+1]),
            .dn_data  (data[k]),
            .dn_sat   (sat_q[k]),
            .ovf_evt  (evt[k])
        );
    end

    always_comb begin
        evt_any = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            evt_any = evt_any | evt[k];
        end
    end

    assign out_valid = vld[STAGES];
    assign sum       = data[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
            ovf       <= 1'b0;
        end else if (flush) begin
            occupancy <= '0;
            ovf       <= 1'b0;
        end else begin
            if (in_xfer && !out_xfer) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!in_xfer && out_xfer) begin
                occupancy <= occupancy - OCC_W'(1);
            end
            if (evt_any) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_scale_pipe.sv
// Scoreboard bench for sum_scale_pipe: a default-width instance and an OUT_W=8 instance share stimulus.
module tb_sum_scale_pipe;

    localparam int IN_W   = 5;
    localparam int STAGES = 4;
    localparam int W_OUT  = 11;
    localparam int N_OUT  = 8;

    typedef struct {
        logic [W_OUT-1:0] w;
        logic [N_OUT-1:0] n;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic             sat_en;
    logic [IN_W-1:0]  a, b, c;
    logic             in_ready, n_in_ready;
    logic             out_valid, n_out_valid;
    logic [W_OUT-1:0] sum;
    logic [N_OUT-1:0] n_sum;
    logic [2:0]       occupancy, n_occupancy;
    logic             ovf, n_ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sum_scale_pipe #(.IN_W(IN_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .occupancy(occupancy), .ovf(ovf)
    );

    sum_scale_pipe #(.IN_W(IN_W), .STAGES(STAGES), .OUT_W(N_OUT), .OCC_W(3)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .a(a), .b(b), .c(c), .sat_en(sat_en), .out_valid(n_out_valid), .out_ready(out_ready),
        .sum(n_sum), .occupancy(n_occupancy), .ovf(n_ovf)
    );

    function automatic int model(input int av, input int bv, input int cv, input bit s, input int w);
        longint v;
        longint lim;
        v   = av + bv + cv;
        lim = longint'(1) << w;
        for (int k = 0; k < STAGES; k++) begin
            if (v >= lim / 2) v = s ? lim - 1 : (v * 2) % lim;
            else              v = v * 2;
        end
        return int'(v);
    endfunction

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (out_valid !== n_out_valid) begin
                failures++;
                $display("FAIL valid_align wide=%b narrow=%b", out_valid, n_out_valid);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected sum=%0d with no beat expected", sum);
                end else begin
                    e = sb.pop_front();
                    if (sum !== e.w) begin
                        failures++;
                        $display("FAIL sb_wide got=%0d expected=%0d", sum, e.w);
                    end
                    checks++;
                    if (n_sum !== e.n) begin
                        failures++;
                        $display("FAIL sb_narrow got=%0d expected=%0d", n_sum, e.n);
                    end
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                e.w = W_OUT'(model(int'(a), int'(b), int'(c), sat_en, W_OUT));
                e.n = N_OUT'(model(int'(a), int'(b), int'(c), sat_en, N_OUT));
                sb.push_back(e);
            end
        end
    end

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_en = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
        checks++; if (sum !== '0) begin failures++; $display("FAIL rst_sum got=%0d expected=0", sum); end
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL rst_occupancy got=%0d expected=0", occupancy); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b expected=0", ovf); end
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1; sat_en = 1'b0; a = 5'd1; b = 5'd2; c = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n != 5) begin failures++; $display("FAIL basic_latency got=%0d expected=5", n); end
        checks++; if (sum !== 11'd96) begin failures++; $display("FAIL basic_sum got=%0d expected=96", sum); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b expected=0", ovf); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_max();
        int n;
        out_ready = 1'b1; sat_en = 1'b0; a = 5'd31; b = 5'd31; c = 5'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (sum !== 11'd1488) begin failures++; $display("FAIL max_sum got=%0d expected=1488", sum); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL max_ovf got=%b expected=0", ovf); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_narrow();
        int n;
        logic [7:0] want;
        for (int m = 0; m < 2; m++) begin
            do_flush();
            out_ready = 1'b1; sat_en = m[0]; a = 5'd31; b = 5'd31; c = 5'd31; in_valid = 1'b1;
            want = (m == 0) ? 8'd208 : 8'd255;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!n_out_valid && n < 20) begin @(posedge clk); #1; n++; end
            checks++; if (n_sum !== want) begin failures++; $display("FAIL narrow_sum mode=%0d got=%0d expected=%0d", m, n_sum, want); end
            checks++; if (n_ovf !== 1'b1) begin failures++; $display("FAIL narrow_ovf mode=%0d got=%b expected=1", m, n_ovf); end
            repeat (2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int outs;
        bit fire;
        logic [W_OUT-1:0] held;
        idx = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = 1'b1;
            a = 5'(idx + 3); b = 5'(2 * idx + 1); c = 5'(31 - idx); sat_en = idx[0];
            fire = in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        checks++; if (idx != 5) begin failures++; $display("FAIL b2b_accepted got=%0d expected=5", idx); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_full got=%b expected=0", in_ready); end
        checks++; if (occupancy !== 3'd5) begin failures++; $display("FAIL b2b_occupancy got=%0d expected=5", occupancy); end
        held = sum;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (sum !== held || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_hold sum=%0d expected=%0d valid=%b", sum, held, out_valid); end
        out_ready = 1'b1;
        outs = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (idx < 8);
            a = 5'(idx + 3); b = 5'(2 * idx + 1); c = 5'(31 - idx); sat_en = idx[0];
            fire = in_valid && in_ready;
            if (out_valid) outs++;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        checks++; if (outs != 8) begin failures++; $display("FAIL b2b_throughput got=%0d expected=8", outs); end
        for (int t = 0; t < 20 && occupancy != 0; t++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL b2b_drain_occ got=%0d expected=0", occupancy); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb_left got=%0d expected=0", sb.size()); end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0; sat_en = 1'b0; a = 5'd31; b = 5'd31; c = 5'd31;
        in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (n_ovf !== 1'b1) begin failures++; $display("FAIL flush_pre_ovf got=%b expected=1", n_ovf); end
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL flush_pre_occ got=%0d expected=3", occupancy); end
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b expected=0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b expected=0", out_valid); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d expected=0", occupancy); end
        checks++; if (n_ovf !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b expected=0", n_ovf); end
        out_ready = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_stale got=%0d expected=0", seen); end
    endtask

    task automatic test_async_reset();
        int n;
        out_ready = 1'b1; sat_en = 1'b0; a = 5'd31; b = 5'd31; c = 5'd31;
        in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0 || n_ovf !== 1'b0 || sum !== '0) begin
            failures++;
            $display("FAIL async_rst valid=%b occ=%0d ovf=%b sum=%0d expected all 0", out_valid, occupancy, n_ovf, sum);
        end
        sb.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a = 5'd7; b = 5'd9; c = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n != 5) begin failures++; $display("FAIL async_latency got=%0d expected=5", n); end
        checks++; if (sum !== 11'd320) begin failures++; $display("FAIL async_sum got=%0d expected=320", sum); end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_narrow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
